rob: RTL and testbench
======================

# rob

Reorder buffer for the out-of-order core, directly downstream of dispatch. It allocates one entry per dispatched instruction and returns that entry's tag to dispatch. It marks entries done when execution units report completion, and retires them strictly in program order. On retirement it releases the old physical register; retiring a mispredicted branch triggers a full pipeline flush.

## Interface
Parameters:
- DEPTH, 16: number of entries; power of two.
- TAG_W, 4: log2(DEPTH); matches the width of the dispatch tag.
- PREG_W, 6: physical register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rob_push_i  in  1  allocate request from dispatch.
- rob_entry_i  in  pipeline_types::rob_entry_t  entry contents to store.
- rob_full_o  out  1  no free entry.
- rob_empty_o  out  1  no valid entry.
- rob_alloc_tag_o  out  TAG_W  tag the next push will receive (the tail pointer).
- cmpl_valid_i  in  1  completion report from the CDB.
- cmpl_tag_i  in  TAG_W  tag of the completing entry.
- cmpl_mispred_i  in  1  the completing branch mispredicted.
- commit_valid_o  out  1  the head entry retires this cycle.
- commit_rd_phys_o  out  PREG_W  rd_phys of the retiring entry.
- commit_rd_old_phys_o  out  PREG_W  rd_old_phys of the retiring entry; goes to the free list.
- commit_pc_o  out  32  pc of the retiring entry.
- flush_o  out  1  one-cycle flush pulse.

## Operation
- State: entry array, head and tail pointers (TAG_W bits each), count (TAG_W+1 bits).
- Push fire = rob_push_i && !rob_full_o && !flush_o.
- On push fire:
  - entry[tail] is written with rob_entry_i, with valid forced to 1, done to 0 and mispredicted to 0.
  - tail increments and wraps from DEPTH-1 to 0.
- Completion:
  - If cmpl_valid_i is high and entry[cmpl_tag_i].valid is set, done is set to 1.
  - mispredicted is set to 1 only if cmpl_mispred_i is high and the entry has is_branch set.
  - Completion to an invalid entry is ignored. Repeated completion of the same entry is idempotent.
- Commit fire = entry[head].valid && entry[head].done.
  - commit_* outputs are combinational from entry[head].
  - On commit fire, entry[head].valid is cleared and head increments with wrap.
- Flush:
  - flush_o = commit fire && entry[head].mispredicted.
  - In the flush cycle the branch itself still commits (commit_valid_o=1).
  - At that edge all valid bits are cleared, head=tail=0 and count=0.
  - A push or completion arriving in the flush cycle is dropped.
- Count update: +1 on push fire only, -1 on commit only, unchanged when both occur. Flush overrides to 0.
- rob_full_o = (count==DEPTH); see Configuration. rob_empty_o = (count==0).
- A push and a completion in the same cycle to different entries both take effect.
- A completion and a commit in the same cycle to different entries both take effect.
- Priority: rst > flush > normal updates.

## Timing
- Reset, and reset mid-operation: all entries are invalid, head=tail=count=0.
  - rob_full_o=0, rob_empty_o=1, rob_alloc_tag_o=0.
  - commit_valid_o=0, flush_o=0, all commit data outputs 0.
- A push in cycle N is visible in the entry array from N+1; rob_alloc_tag_o advances at N+1.
- A completion in cycle N makes the entry committable in N+1.
- Minimum push-to-commit latency is 2 cycles (push at N, complete at N+1, commit at N+2).
- Commit width is 1 per cycle. Allocation width is 1 per cycle.
- Flush is a single-cycle pulse; the ROB accepts a push again from the cycle after the flush.
- There is no combinational path from rob_push_i to any output.

## Configuration
- Macro: ROB_FULL_BYPASS_EN.
- Undefined: rob_full_o = (count==DEPTH). A full ROB stalls dispatch for one cycle even when the head is committing.
- Defined: rob_full_o = (count==DEPTH) && !commit fire. When full, a commit and a push may occur in the same cycle; the freed head slot equals the tail slot and is rewritten at the edge.
  - The added path to rob_full_o depends only on registered state.

## Test plan
- Reset, then 3 pushes in consecutive cycles -> tags 0,1,2 assigned; rob_alloc_tag_o=3; count=3; commit_valid_o=0 throughout.
- Complete tags 2, 0, 1 in consecutive cycles -> commits occur in order 0,1,2, each carrying its rd_old_phys; rob_empty_o=1 afterward.
- 16 pushes with no completions -> rob_full_o=1 and a 17th push is ignored. Complete tag 0, then push while the head commits:
  - macro undefined: the push is accepted one cycle later;
  - macro defined: the push is accepted in the same cycle at tag 0.
- Push branch (is_branch=1) plus 2 ALU ops, complete all with cmpl_mispred_i=1 on the branch -> branch commits with flush_o=1; next cycle count=0, rob_alloc_tag_o=0, younger ops never commit.
- 20 push/complete/commit cycles -> tail wraps 15->0 with in-order commit and no lost entries; a completion with cmpl_mispred_i=1 on a non-branch does not flush.
- Assert rst with 5 valid entries, 2 of them done -> next cycle all outputs are at their reset values and no commit occurs.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: in-order allocate/retire, out-of-order completion, flush on a
// mispredicted branch retiring. Optional macro ROB_FULL_BYPASS_EN lets a push use the slot the head frees.
package pipeline_types;
  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredicted;
    logic        is_branch;
    logic [31:0] pc;
    logic [5:0]  rd_phys;
    logic [5:0]  rd_old_phys;
  } rob_entry_t;
endpackage

module rob #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rob_push_i,
  input  pipeline_types::rob_entry_t rob_entry_i,
  output logic                     rob_full_o,
  output logic                     rob_empty_o,
  output logic [TAG_W-1:0]         rob_alloc_tag_o,
  input  logic                     cmpl_valid_i,
  input  logic [TAG_W-1:0]         cmpl_tag_i,
  input  logic                     cmpl_mispred_i,
  output logic                     commit_valid_o,
  output logic [PREG_W-1:0]        commit_rd_phys_o,
  output logic [PREG_W-1:0]        commit_rd_old_phys_o,
  output logic [31:0]              commit_pc_o,
  output logic                     flush_o
);
  import pipeline_types::*;

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   cnt_q, cnt_d;
  rob_entry_t       head_ent;
  logic             commit_fire, push_fire;

  assign head_ent    = ent_q[head_q];
  assign commit_fire = head_ent.valid & head_ent.done;
  assign flush_o     = commit_fire & head_ent.mispredicted;

`ifdef ROB_FULL_BYPASS_EN
  // commit_fire comes only from flops, so this keeps rob_full_o free of input paths
  assign rob_full_o = (cnt_q == FULL_CNT) & ~commit_fire;
`else
  assign rob_full_o = (cnt_q == FULL_CNT);
`endif

  assign rob_empty_o          = (cnt_q == '0);
  assign rob_alloc_tag_o      = tail_q;
  assign push_fire            = rob_push_i & ~rob_full_o & ~flush_o;
  assign commit_valid_o       = commit_fire;
  assign commit_rd_phys_o     = PREG_W'(head_ent.rd_phys);
  assign commit_rd_old_phys_o = PREG_W'(head_ent.rd_old_phys);
  assign commit_pc_o          = head_ent.pc;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_o) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (cmpl_valid_i && ent_q[cmpl_tag_i].valid) begin
        ent_d[cmpl_tag_i].done = 1'b1;
        if (cmpl_mispred_i && ent_q[cmpl_tag_i].is_branch)
          ent_d[cmpl_tag_i].mispredicted = 1'b1;
      end
      if (commit_fire) begin
        ent_d[head_q].valid = 1'b0;
        head_d = head_q + TAG_W'(1);
      end
      // push last: under bypass it may reuse the slot the commit just freed
      if (push_fire) begin
        ent_d[tail_q]              = rob_entry_i;
        ent_d[tail_q].valid        = 1'b1;
        ent_d[tail_q].done         = 1'b0;
        ent_d[tail_q].mispredicted = 1'b0;
        tail_d = tail_q + TAG_W'(1);
      end
      case ({push_fire, commit_fire})
        2'b10:   cnt_d = cnt_q + (TAG_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (TAG_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: ordering, full stall/bypass, flush, wrap, reset.
module tb_rob;
  import pipeline_types::*;

  logic        clk = 0, rst = 1;
  logic        push = 0;
  rob_entry_t  ent = '0;
  logic        full, empty;
  logic [3:0]  atag;
  logic        cv = 0, cmisp = 0;
  logic [3:0]  ctag = '0;
  logic        cval;
  logic [5:0]  crd, cold;
  logic [31:0] cpc;
  logic        flush;

  int chk = 0, pass = 0, fl_cnt = 0;
  logic [5:0] q[$];

  rob dut (
    .clk(clk), .rst(rst), .rob_push_i(push), .rob_entry_i(ent),
    .rob_full_o(full), .rob_empty_o(empty), .rob_alloc_tag_o(atag),
    .cmpl_valid_i(cv), .cmpl_tag_i(ctag), .cmpl_mispred_i(cmisp),
    .commit_valid_o(cval), .commit_rd_phys_o(crd), .commit_rd_old_phys_o(cold),
    .commit_pc_o(cpc), .flush_o(flush)
  );

  always #5 clk = ~clk;

  // retirement monitor: records rd_old_phys of every commit
  always @(negedge clk) begin
    if (cval) q.push_back(cold);
    if (flush) fl_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic rob_entry_t mk(input logic br, input logic [31:0] pc,
                                    input logic [5:0] rd, input logic [5:0] old);
    rob_entry_t e;
    e = '0;
    e.is_branch = br; e.pc = pc; e.rd_phys = rd; e.rd_old_phys = old;
    e.valid = 1'b0;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1; push = 0; cv = 0; cmisp = 0;
    step();
    rst = 0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && !empty; i++) step();
    chk++; if (empty !== 1'b1) $display("FAIL %s_drain_timeout got empty=%0b want 1", nm, empty); else pass++;
  endtask

  task automatic test_reset();
    do_reset();
    chk++; if (full !== 1'b0)  $display("FAIL rst_full got %0b want 0", full); else pass++;
    chk++; if (empty !== 1'b1) $display("FAIL rst_empty got %0b want 1", empty); else pass++;
    chk++; if (atag !== 4'd0)  $display("FAIL rst_atag got %0d want 0", atag); else pass++;
    chk++; if ({cval, flush, crd, cold, cpc} !== '0)
      $display("FAIL rst_commit got v=%0b f=%0b rd=%0d old=%0d pc=%0h want 0", cval, flush, crd, cold, cpc);
    else pass++;
  endtask

  task automatic test_in_order();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      chk++; if (atag !== 4'(i)) $display("FAIL io_tag%0d got %0d want %0d", i, atag, i); else pass++;
      ent = mk(1'b0, 32'h100 + i, 6'(10 + i), 6'(20 + i));
      push = 1; step();
      chk++; if (cval !== 1'b0) $display("FAIL io_nocommit%0d got %0b want 0", i, cval); else pass++;
    end
    push = 0;
    chk++; if (atag !== 4'd3) $display("FAIL io_atag3 got %0d want 3", atag); else pass++;
    cv = 1; ctag = 4'd2; step();
    chk++; if (cval !== 1'b0) $display("FAIL io_wait_head got %0b want 0", cval); else pass++;
    ctag = 4'd0; step();
    chk++; if ({cval, cold, crd, cpc} !== {1'b1, 6'd20, 6'd10, 32'h100})
      $display("FAIL io_c0 got v=%0b old=%0d rd=%0d pc=%0h want 1/20/10/100", cval, cold, crd, cpc);
    else pass++;
    ctag = 4'd1; step();
    chk++; if ({cval, cold} !== {1'b1, 6'd21}) $display("FAIL io_c1 got v=%0b old=%0d want 1/21", cval, cold); else pass++;
    cv = 0; step();
    chk++; if ({cval, cold} !== {1'b1, 6'd22}) $display("FAIL io_c2 got v=%0b old=%0d want 1/22", cval, cold); else pass++;
    step();
    chk++; if ({empty, cval} !== 2'b10) $display("FAIL io_empty got e=%0b v=%0b want 1/0", empty, cval); else pass++;
    chk++; if (q.size() != 3 || q[0] !== 6'd20 || q[1] !== 6'd21 || q[2] !== 6'd22)
      $display("FAIL io_order got n=%0d want 20,21,22", q.size());
    else pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ent = mk(1'b0, 32'h200 + i, 6'(i), 6'(30 + i)); push = 1; step();
    end
    chk++; if ({full, atag} !== {1'b1, 4'd0}) $display("FAIL full_set got f=%0b tag=%0d want 1/0", full, atag); else pass++;
    ent = mk(1'b0, 32'h2ff, 6'd0, 6'd63); step();
    chk++; if ({full, atag} !== {1'b1, 4'd0}) $display("FAIL full_17th got f=%0b tag=%0d want 1/0", full, atag); else pass++;
    push = 0; cv = 1; ctag = 4'd0; step();
    cv = 0;
    chk++; if ({cval, cold} !== {1'b1, 6'd30}) $display("FAIL full_head got v=%0b old=%0d want 1/30", cval, cold); else pass++;
`ifdef ROB_FULL_BYPASS_EN
    chk++; if (full !== 1'b0) $display("FAIL full_bypass got %0b want 0", full); else pass++;
    ent = mk(1'b0, 32'h300, 6'd5, 6'd50); push = 1; step(); push = 0;
    chk++; if ({full, atag} !== {1'b1, 4'd1}) $display("FAIL full_same got f=%0b tag=%0d want 1/1", full, atag); else pass++;
`else
    chk++; if (full !== 1'b1) $display("FAIL full_stall got %0b want 1", full); else pass++;
    ent = mk(1'b0, 32'h300, 6'd5, 6'd50); push = 1; step();
    chk++; if ({full, atag} !== {1'b0, 4'd0}) $display("FAIL full_held got f=%0b tag=%0d want 0/0", full, atag); else pass++;
    step(); push = 0;
    chk++; if ({full, atag} !== {1'b1, 4'd1}) $display("FAIL full_late got f=%0b tag=%0d want 1/1", full, atag); else pass++;
`endif
    q.delete();
    cv = 1;
    for (int k = 1; k < 17; k++) begin ctag = 4'(k); step(); end
    cv = 0;
    drain("full");
    chk++; if (q.size() != 16) $display("FAIL full_cnt got %0d want 16", q.size()); else pass++;
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      logic [5:0] exp;
      exp = (k == 15) ? 6'd50 : 6'(31 + k);
      chk++; if (q[k] !== exp) $display("FAIL full_ord%0d got %0d want %0d", k, q[k], exp); else pass++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    q.delete();
    ent = mk(1'b1, 32'h400, 6'd1, 6'd60); push = 1; step();
    ent = mk(1'b0, 32'h404, 6'd2, 6'd61); step();
    ent = mk(1'b0, 32'h408, 6'd3, 6'd62); step();
    push = 0;
    cv = 1; cmisp = 0; ctag = 4'd1; step();
    ctag = 4'd2; step();
    ctag = 4'd0; cmisp = 1; step();
    chk++; if ({cval, flush, cold} !== {1'b1, 1'b1, 6'd60})
      $display("FAIL fl_pulse got v=%0b f=%0b old=%0d want 1/1/60", cval, flush, cold);
    else pass++;
    cv = 1; ctag = 4'd1; cmisp = 1;
    ent = mk(1'b0, 32'h500, 6'd9, 6'd9); push = 1; step();
    cv = 0; cmisp = 0;
    chk++; if ({empty, atag, cval, flush} !== {1'b1, 4'd0, 1'b0, 1'b0})
      $display("FAIL fl_after got e=%0b tag=%0d v=%0b f=%0b want 1/0/0/0", empty, atag, cval, flush);
    else pass++;
    step(); push = 0;
    chk++; if ({empty, atag} !== {1'b0, 4'd1}) $display("FAIL fl_repush got e=%0b tag=%0d want 0/1", empty, atag); else pass++;
    step(); step();
    chk++; if (q.size() != 1 || q[0] !== 6'd60) $display("FAIL fl_younger got n=%0d want only 60", q.size()); else pass++;
  endtask

  task automatic test_wrap();
    int f0;
    do_reset();
    q.delete(); f0 = fl_cnt;
    for (int i = 0; i < 20; i++) begin
      ent = mk(1'b0, 32'h600 + i, 6'(i), 6'(i)); push = 1;
      cv = (i > 0); ctag = 4'(i - 1); cmisp = 1;
      step();
    end
    push = 0;
    chk++; if (atag !== 4'd4) $display("FAIL wr_atag got %0d want 4", atag); else pass++;
    cv = 1; ctag = 4'd3; step();
    cv = 0; cmisp = 0;
    drain("wrap");
    chk++; if (fl_cnt != f0) $display("FAIL wr_noflush got %0d flushes want 0", fl_cnt - f0); else pass++;
    chk++; if (q.size() != 20) $display("FAIL wr_cnt got %0d want 20", q.size()); else pass++;
    for (int k = 0; k < 20 && k < q.size(); k += 5) begin
      chk++; if (q[k] !== 6'(k)) $display("FAIL wr_ord%0d got %0d want %0d", k, q[k], k); else pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ent = mk(1'b0, 32'h700 + i, 6'(40 + i), 6'(40 + i)); push = 1; step();
    end
    push = 0;
    cv = 1; ctag = 4'd1; step();
    ctag = 4'd2; step();
    cv = 0;
    rst = 1; step(); rst = 0;
    q.delete();
    chk++; if ({full, empty, atag, cval, flush, crd, cold, cpc} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 6'd0, 6'd0, 32'd0})
      $display("FAIL rm_state got f=%0b e=%0b tag=%0d v=%0b fl=%0b rd=%0d old=%0d pc=%0h want reset", full, empty, atag, cval, flush, crd, cold, cpc);
    else pass++;
    step(); step();
    chk++; if (q.size() != 0 || cval !== 1'b0) $display("FAIL rm_nocommit got n=%0d v=%0b want 0/0", q.size(), cval); else pass++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
